// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response pair.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects word accesses at odd addresses.
module dmem_responder #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_nbytes,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    // Handshake: a request transfers on the edge where req_valid && req_ready;
    // a response transfers on the edge where rsp_valid && rsp_ready, and
    // rsp_valid/rsp_rdata/rsp_err hold steady until then.

    localparam int unsigned AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  nbytes_q, nbytes_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [MEM_BYTES];

    logic          accept;
    logic          perform;
    logic          word_acc;
    logic          access_err;
    logic [AW-1:0] idx_lo;
    logic [AW-1:0] idx_hi;
    logic [15:0]   rd_word;
    logic          we_lo;
    logic          we_hi;

    assign accept   = req_valid && ready_q;
    assign perform  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign word_acc = (nbytes_q == 2'b10);
    // The high-byte index wraps at the top of storage for odd word accesses.
    assign idx_lo   = addr_q[AW-1:0];
    assign idx_hi   = idx_lo + AW'(1);
    assign rd_word  = word_acc ? {mem_q[idx_hi], mem_q[idx_lo]} : {8'h00, mem_q[idx_lo]};
    assign we_lo    = perform && wr_q && !access_err;
    assign we_hi    = we_lo && word_acc;

    always_comb begin
        access_err = ((nbytes_q != 2'b01) && (nbytes_q != 2'b10)) || (32'(addr_q) >= MEM_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
        if (word_acc && addr_q[0]) begin
            access_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            nbytes_q <= 2'b00;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            nbytes_q <= nbytes_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem_q[idx_lo] <= wdata_q[7:0];
        end
        if (we_hi) begin
            mem_q[idx_hi] <= wdata_q[15:8];
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        nbytes_d = nbytes_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                // ready is registered so it only rises a full cycle after entering IDLE.
                ready_d = !accept;
                if (accept) begin
                    wr_d     = req_wr;
                    nbytes_d = req_nbytes;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'(WAIT_CYCLES);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    err_d   = access_err;
                    rdata_d = (wr_q || access_err) ? 16'h0000 : rd_word;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = ready_q;
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of requests with expected responses fed through
// a scoreboard queue, plus hand-written reset sequences.
module tb_dmem_responder;

    localparam int unsigned MEM_BYTES   = 1024;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_nbytes;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  nb;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          stall;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .MEM_BYTES  (MEM_BYTES),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_nbytes(req_nbytes),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic [1:0] nb,
                                input logic [15:0] addr, input logic [15:0] wdata, input int stall,
                                input logic [15:0] er, input logic ee);
        vec_t v;
        v.name = name; v.wr = wr; v.nb = nb; v.addr = addr; v.wdata = wdata;
        v.stall = stall; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check_outputs_zero(input string name);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    task automatic wait_ready(input string name, output logic ok);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = req_ready;
        check({name, "_ready_wait"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [16:0] e;
        logic [15:0] hold;
        logic        ok;
        int          lat;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        wait_ready(v.name, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        req_valid  = 1'b1;
        req_wr     = v.wr;
        req_nbytes = v.nb;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk); #1;
        lat = 0;
        // Junk on the request inputs while busy must be ignored.
        while (!rsp_valid && lat < 40) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_wr     = 1'($urandom_range(0, 1));
            req_nbytes = 2'($urandom_range(0, 3));
            req_addr   = 16'($urandom);
            req_wdata  = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check({v.name, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        if (!rsp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        e    = exp_q.pop_front();
        hold = rsp_rdata;
        check({v.name, "_rdata"}, 32'(rsp_rdata), 32'(e[15:0]));
        check({v.name, "_err"}, 32'(rsp_err), 32'(e[16]));
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            check({v.name, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({v.name, "_stall_rdata"}, 32'(rsp_rdata), 32'(hold));
            check({v.name, "_stall_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({v.name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({v.name, "_done_ready_low"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check({v.name, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic ok;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_nbytes = 2'b00;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        rsp_ready  = 1'b0;

        vecs.push_back(mk("wr_beef",     1, 2'b10, 16'h0010, 16'hBEEF, 0, 16'h0000, 0));
        vecs.push_back(mk("rd_beef",     0, 2'b10, 16'h0010, 16'h0000, 0, 16'hBEEF, 0));
        vecs.push_back(mk("wrb_5a",      1, 2'b01, 16'h0011, 16'hC35A, 0, 16'h0000, 0));
        vecs.push_back(mk("rdb_5a",      0, 2'b01, 16'h0011, 16'h0000, 0, 16'h005A, 0));
        vecs.push_back(mk("rd_5aef",     0, 2'b10, 16'h0010, 16'h0000, 0, 16'h5AEF, 0));
        vecs.push_back(mk("rd_stall",    0, 2'b10, 16'h0010, 16'h0000, 5, 16'h5AEF, 0));
        vecs.push_back(mk("wr_1111",     1, 2'b10, 16'h0000, 16'h1111, 0, 16'h0000, 0));
        vecs.push_back(mk("wr_oob",      1, 2'b10, 16'h0400, 16'hDEAD, 0, 16'h0000, 1));
        vecs.push_back(mk("wr_nb11",     1, 2'b11, 16'h0000, 16'h7777, 0, 16'h0000, 1));
        vecs.push_back(mk("rd_nb00",     0, 2'b00, 16'h0010, 16'h0000, 0, 16'h0000, 1));
        vecs.push_back(mk("rdb_oob",     0, 2'b01, 16'hFFFF, 16'h0000, 0, 16'h0000, 1));
        vecs.push_back(mk("rd_0000",     0, 2'b10, 16'h0000, 16'h0000, 0, 16'h1111, 0));
        vecs.push_back(mk("rd_0010_2",   0, 2'b10, 16'h0010, 16'h0000, 0, 16'h5AEF, 0));
        vecs.push_back(mk("wr_5555",     1, 2'b10, 16'h0020, 16'h5555, 0, 16'h0000, 0));
        vecs.push_back(mk("wr_7766",     1, 2'b10, 16'h0022, 16'h7766, 0, 16'h0000, 0));
        vecs.push_back(mk("wrb_3ff",     1, 2'b01, 16'h03FF, 16'h0001, 0, 16'h0000, 0));
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back(mk("wr_odd_21",   1, 2'b10, 16'h0021, 16'h1234, 0, 16'h0000, 1));
        vecs.push_back(mk("rdb_21",      0, 2'b01, 16'h0021, 16'h0000, 0, 16'h0055, 0));
        vecs.push_back(mk("rdb_22",      0, 2'b01, 16'h0022, 16'h0000, 0, 16'h0066, 0));
        vecs.push_back(mk("rd_20",       0, 2'b10, 16'h0020, 16'h0000, 0, 16'h5555, 0));
        vecs.push_back(mk("wr_wrap",     1, 2'b10, 16'h03FF, 16'hAAAA, 0, 16'h0000, 1));
        vecs.push_back(mk("rdb_3ff",     0, 2'b01, 16'h03FF, 16'h0000, 0, 16'h0001, 0));
        vecs.push_back(mk("rdb_000",     0, 2'b01, 16'h0000, 16'h0000, 0, 16'h0011, 0));
        vecs.push_back(mk("rd_wrap",     0, 2'b10, 16'h03FF, 16'h0000, 0, 16'h0000, 1));
`else
        vecs.push_back(mk("wr_odd_21",   1, 2'b10, 16'h0021, 16'h1234, 0, 16'h0000, 0));
        vecs.push_back(mk("rdb_21",      0, 2'b01, 16'h0021, 16'h0000, 0, 16'h0034, 0));
        vecs.push_back(mk("rdb_22",      0, 2'b01, 16'h0022, 16'h0000, 0, 16'h0012, 0));
        vecs.push_back(mk("rd_20",       0, 2'b10, 16'h0020, 16'h0000, 0, 16'h3455, 0));
        vecs.push_back(mk("wr_wrap",     1, 2'b10, 16'h03FF, 16'hAAAA, 0, 16'h0000, 0));
        vecs.push_back(mk("rdb_3ff",     0, 2'b01, 16'h03FF, 16'h0000, 0, 16'h00AA, 0));
        vecs.push_back(mk("rdb_000",     0, 2'b01, 16'h0000, 16'h0000, 0, 16'h00AA, 0));
        vecs.push_back(mk("rd_wrap",     0, 2'b10, 16'h03FF, 16'h0000, 0, 16'hAAAA, 0));
`endif
        vecs.push_back(mk("rdb_23",      0, 2'b01, 16'h0023, 16'h0000, 0, 16'h0077, 0));
        vecs.push_back(mk("rd_0010_3",   0, 2'b10, 16'h0010, 16'h0000, 0, 16'h5AEF, 0));

        // Power-on reset: outputs held at zero across clock edges.
        #3;
        check_outputs_zero("por_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_outputs_zero("por_clocked");
        #2;
        reset = 1'b1;
        #1;
        check({"por", "_ready_before_edge"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check({"por", "_ready_first_edge"}, 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Reset while a write sits in WAIT: it must be dropped.
        wait_ready("rst_mid", ok);
        if (ok) begin
            req_valid  = 1'b1;
            req_wr     = 1'b1;
            req_nbytes = 2'b10;
            req_addr   = 16'h0010;
            req_wdata  = 16'hFFFF;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(posedge clk); #2;
            reset = 1'b0;
            #1;
            check_outputs_zero("rst_mid_async");
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
            end
            check_outputs_zero("rst_mid_clocked");
            #2;
            reset = 1'b1;
            #1;
            check({"rst_mid", "_ready_before_edge"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check({"rst_mid", "_ready_first_edge"}, 32'(req_ready), 32'd1);
        end
        run_vec(mk("rd_after_rst", 0, 2'b10, 16'h0010, 16'h0000, 0, 16'h5AEF, 0));

        check({"scoreboard", "_empty"}, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, size of byte-addressed storage (power of two, >=2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access latency in cycles (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_nbytes  input  2  access size: 2'b01 byte, 2'b10 word, other codes invalid.
REQ-009 SHALL have port req_addr  input  16  byte address.
REQ-010 SHALL have port req_wdata  input  16  write data; byte writes use bits [7:0].
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected, storage unchanged.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-017 On acceptance SHALL latch wr, nbytes, addr, wdata, load wait counter with WAIT_CYCLES and go to WAIT.
REQ-018 In WAIT the counter SHALL decrement once per cycle; on the edge where it is 0 the access is performed and the state goes to RESP.
REQ-019 With acceptance at edge k, rsp_valid SHALL rise after edge k+WAIT_CYCLES+1 (WAIT_CYCLES=0 gives one-cycle latency).
REQ-020 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid && rsp_ready, then the state returns to IDLE and rsp_valid drops on that edge.
REQ-021 req_ready SHALL not rise in the cycle a response completes; next acceptance earliest one cycle after return to IDLE.
REQ-022 Storage SHALL be little-endian: word at a holds low byte at a, high byte at a+1.
REQ-023 Byte read SHALL return the byte zero-extended to 16 bits; word read returns {mem[a+1], mem[a]}.
REQ-024 Byte write SHALL update only mem[a]; word write updates mem[a] and mem[a+1].
REQ-025 Invalid req_nbytes or req_addr >= MEM_BYTES SHALL give rsp_err=1, rsp_rdata=0, no storage change.
REQ-026 Write responses SHALL carry rsp_err as computed and rsp_rdata=0.
REQ-027 Inputs other than rsp_ready SHALL be ignored outside IDLE.

Reset
REQ-028 While reset=0: state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, regardless of clk.
REQ-029 req_ready SHALL rise on the first rising edge after reset deasserts.
REQ-030 Reset mid-transaction SHALL drop it; a write not yet performed (still in WAIT) SHALL not modify storage.
REQ-031 Storage contents SHALL not be cleared by reset.

Configuration
REQ-032 With macro DMEM_ALIGN_CHECK_EN defined, a word access with addr[0]=1 SHALL give rsp_err=1 and no storage change.
REQ-033 Without DMEM_ALIGN_CHECK_EN, an odd-address word access SHALL be performed on bytes a and (a+1) mod MEM_BYTES, same latency, rsp_err=0.

Verification
REQ-034 Reset, write word 0xBEEF @0x0010, read word @0x0010 -> rsp_rdata=0xBEEF, rsp_err=0, rsp_valid exactly WAIT_CYCLES+1 cycles after each accept.
REQ-035 After REQ-034, byte write 0x5A @0x0011, read byte @0x0011 -> 0x005A; read word @0x0010 -> 0x5AEF.
REQ-036 Read @0x0010 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; completes on first rsp_ready=1.
REQ-037 Word write @0x0400 (MEM_BYTES=1024) and nbytes=2'b11 @0x0000 -> rsp_err=1, rsp_rdata=0, subsequent reads unchanged.
REQ-038 Word write 0x1234 @0x0021: with DMEM_ALIGN_CHECK_EN -> rsp_err=1, storage unchanged; without -> mem[0x21]=0x34, mem[0x22]=0x12; word write 0xAAAA @0x03FF -> mem[0x3FF]=0xAA, mem[0x000]=0xAA.
REQ-039 Assert reset during WAIT of write 0xFFFF @0x0010 -> outputs zero immediately, later read @0x0010 returns prior value.
